// File: rtl/read_flash_control.sv
// rtl/read_flash_control.sv - read-side page controller: fetches the next valid NAND page into page RAM bank 1
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   en_read_i                   level request to read the next valid page (sampled in IDLE)
//   end_read_o, read_status_o   one-cycle completion pulse; status 0 none, 1 page, 2 empty, 3 fail
//   en_read_page_o              request to the basic page-read engine, held until end_read_page_i
//   end_read_page_i             engine completion pulse; read_success_i valid with it (1 ok, 2 fail)
//   read_data_valid_i, read_data_cnt_i, read_data_i   engine byte stream (cnt 0..PAGE_BYTES)
//   read_addr_row_o             current row: [18:7] block, [6:0] page
//   write_addr_row_i            writer's current row; reading stops when the rows meet
//   init_addr_row_i, en_init_read_addr_i, end_init_read_addr_o   start-row load handshake
//   read_en_ram_o, read_ram_addr_o, read_ram_datain_o            page RAM port A write side
module read_flash_control #(
    parameter int PAGE_BYTES = 8192,
    parameter int INFO_PAGE  = 127,
    parameter int RETRY_MAX  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_read_i,
    output logic        end_read_o,
    output logic [1:0]  read_status_o,
    output logic        en_read_page_o,
    input  logic        end_read_page_i,
    input  logic [1:0]  read_success_i,
    input  logic        read_data_valid_i,
    input  logic [13:0] read_data_cnt_i,
    input  logic [7:0]  read_data_i,
    output logic [23:0] read_addr_row_o,
    input  logic [23:0] write_addr_row_i,
    input  logic [23:0] init_addr_row_i,
    input  logic        en_init_read_addr_i,
    output logic        end_init_read_addr_o,
    output logic        read_en_ram_o,
    output logic [14:0] read_ram_addr_o,
    output logic [7:0]  read_ram_datain_o
);

    localparam logic [13:0] PAGE_CNT  = PAGE_BYTES[13:0];
    localparam logic [6:0]  INFO_PG   = INFO_PAGE[6:0];
    localparam logic [1:0]  RETRY_LIM = RETRY_MAX[1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_WAIT,
        S_EVAL,
        S_NEXT_PAGE,
        S_NEXT_BLOCK,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] row_q, row_d;
    logic [1:0]  retry_q, retry_d;
    logic        bad_q, bad_d;
    logic [1:0]  succ_q, succ_d;     // engine status captured with end_read_page
    logic [1:0]  pend_q, pend_d;     // result decided in EVAL, published on the way to DONE
    logic [1:0]  status_q, status_d;
    logic        en_page_q, en_page_d;
    logic        init_done_q, init_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            retry_q     <= '0;
            bad_q       <= 1'b0;
            succ_q      <= '0;
            pend_q      <= '0;
            status_q    <= '0;
            en_page_q   <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            retry_q     <= retry_d;
            bad_q       <= bad_d;
            succ_q      <= succ_d;
            pend_q      <= pend_d;
            status_q    <= status_d;
            en_page_q   <= en_page_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        retry_d     = retry_q;
        bad_d       = bad_q;
        succ_d      = succ_q;
        pend_d      = pend_q;
        status_d    = status_q;
        en_page_d   = en_page_q;
        init_done_d = init_done_q;

        // Start-row load is only safe while no page walk is in progress.
        if (state_q == S_IDLE && en_init_read_addr_i) begin
            row_d       = init_addr_row_i;
            init_done_d = 1'b1;
        end else if (!en_init_read_addr_i) begin
            init_done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (en_read_i) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (row_q == write_addr_row_i) begin
                    status_d = 2'd2;
                    state_d  = S_DONE;
                end else if (row_q[6:0] == INFO_PG) begin
                    state_d = S_NEXT_BLOCK;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                en_page_d = 1'b1;
                bad_d     = 1'b0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // Spare byte 0 arrives at cnt==PAGE_BYTES; anything but 0xFF marks the block bad.
                if (read_data_valid_i && read_data_cnt_i == PAGE_CNT && read_data_i != 8'hFF) begin
                    bad_d = 1'b1;
                end
                if (end_read_page_i) begin
                    en_page_d = 1'b0;
                    succ_d    = read_success_i;
                    state_d   = S_EVAL;
                end
            end
            S_EVAL: begin
                if (bad_q) begin
                    retry_d = '0;
                    state_d = S_NEXT_BLOCK;
                end else if (succ_q == 2'd2) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 2'd1;
                        state_d = S_REQ;
                    end else begin
                        pend_d  = 2'd3;
                        state_d = S_NEXT_PAGE;
                    end
                end else begin
                    pend_d  = 2'd1;
                    state_d = S_NEXT_PAGE;
                end
            end
            S_NEXT_PAGE: begin
                row_d   = row_q + 24'd1;
                retry_d = '0;
                if (pend_q != 2'd0) begin
                    status_d = pend_q;
                    pend_d   = '0;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_NEXT_BLOCK: begin
                // Block field wraps within [18:7]; the upper row bits are left alone.
                row_d   = {row_q[23:19], row_q[18:7] + 12'd1, 7'd0};
                state_d = S_CHECK;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign end_read_o           = (state_q == S_DONE);
    assign read_status_o        = status_q;
    assign en_read_page_o       = en_page_q;
    assign read_addr_row_o      = row_q;
    assign end_init_read_addr_o = init_done_q;

    // Data bytes go straight to bank 1 of the page RAM; spare bytes are never stored.
    assign read_en_ram_o     = read_data_valid_i && (read_data_cnt_i < PAGE_CNT) && (state_q == S_WAIT);
    assign read_ram_addr_o   = read_en_ram_o ? {2'b01, read_data_cnt_i[12:0]} : 15'd0;
    assign read_ram_datain_o = read_en_ram_o ? read_data_i : 8'd0;

endmodule

// File: tb/tb_read_flash_control.sv
// tb/tb_read_flash_control.sv - directed self-checking bench for read_flash_control
module tb_read_flash_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_read;
    logic        end_read;
    logic [1:0]  read_status;
    logic        en_read_page;
    logic        end_read_page;
    logic [1:0]  read_success;
    logic        read_data_valid;
    logic [13:0] read_data_cnt;
    logic [7:0]  read_data;
    logic [23:0] read_addr_row;
    logic [23:0] write_addr_row;
    logic [23:0] init_addr_row;
    logic        en_init_read_addr;
    logic        end_init_read_addr;
    logic        read_en_ram;
    logic [14:0] read_ram_addr;
    logic [7:0]  read_ram_datain;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    read_flash_control dut (
        .clk                  (clk),
        .rst                  (rst),
        .en_read_i            (en_read),
        .end_read_o           (end_read),
        .read_status_o        (read_status),
        .en_read_page_o       (en_read_page),
        .end_read_page_i      (end_read_page),
        .read_success_i       (read_success),
        .read_data_valid_i    (read_data_valid),
        .read_data_cnt_i      (read_data_cnt),
        .read_data_i          (read_data),
        .read_addr_row_o      (read_addr_row),
        .write_addr_row_i     (write_addr_row),
        .init_addr_row_i      (init_addr_row),
        .en_init_read_addr_i  (en_init_read_addr),
        .end_init_read_addr_o (end_init_read_addr),
        .read_en_ram_o        (read_en_ram),
        .read_ram_addr_o      (read_ram_addr),
        .read_ram_datain_o    (read_ram_datain)
    );

    logic [7:0]  ram [0:32767];
    int          ram_writes = 0;
    int          rises = 0;
    int          info_reqs = 0;
    logic        prev_rp = 1'b0;
    logic [23:0] last_req_row = '0;

    always @(posedge clk) begin
        if (read_en_ram) begin
            ram[read_ram_addr] <= read_ram_datain;
            ram_writes         <= ram_writes + 1;
        end
        prev_rp <= en_read_page;
        if (en_read_page && !prev_rp) begin
            rises        <= rises + 1;
            last_req_row <= read_addr_row;
            if (read_addr_row[6:0] == 7'h7F) info_reqs <= info_reqs + 1;
        end
    end

    function automatic logic [7:0] pat(input int i);
        return 8'(i) ^ 8'(i >> 5);
    endfunction

    task automatic set_row(input logic [23:0] r);
        @(negedge clk);
        init_addr_row     = r;
        en_init_read_addr = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (read_addr_row !== r || end_init_read_addr !== 1'b1) begin
            n_err++;
            $display("FAIL init_load row=%h ack=%b expected row=%h ack=1", read_addr_row, end_init_read_addr, r);
        end
        en_init_read_addr = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (end_init_read_addr !== 1'b0) begin
            n_err++;
            $display("FAIL init_ack_clear ack=%b expected 0", end_init_read_addr);
        end
    endtask

    task automatic pulse_read();
        @(negedge clk);
        en_read = 1'b1;
        @(negedge clk);
        en_read = 1'b0;
    endtask

    task automatic run_page(input int nbytes, input logic [7:0] spare, input logic [1:0] succ, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (en_read_page) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) begin
            for (int i = 0; i < nbytes; i++) begin
                read_data_valid = 1'b1;
                read_data_cnt   = 14'(i);
                read_data       = pat(i);
                @(negedge clk);
            end
            read_data_valid = 1'b1;
            read_data_cnt   = 14'd8192;
            read_data       = spare;
            @(negedge clk);
            read_data_valid = 1'b0;
            end_read_page   = 1'b1;
            read_success    = succ;
            @(negedge clk);
            end_read_page   = 1'b0;
            read_success    = 2'd0;
        end
    endtask

    task automatic wait_end(output bit got);
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (end_read) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (end_read !== 1'b0 || read_status !== 2'd0 || en_read_page !== 1'b0 || read_addr_row !== 24'd0 ||
            end_init_read_addr !== 1'b0 || read_en_ram !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs end=%b st=%0d rp=%b row=%h ack=%b ram=%b expected all 0",
                     end_read, read_status, en_read_page, read_addr_row, end_init_read_addr, read_en_ram);
        end
    endtask

    task automatic test_good_page();
        bit ok;
        int w0;
        int bad_bytes;
        write_addr_row = 24'h000008;
        set_row(24'h000005);
        w0 = ram_writes;
        pulse_read();
        run_page(8192, 8'hFF, 2'd1, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL good_req en_read_page=0 expected 1"); end
        wait_end(ok);
        n_cmp++;
        if (!ok || read_status !== 2'd1) begin
            n_err++;
            $display("FAIL good_status end=%b status=%0d expected end=1 status=1", ok, read_status);
        end
        n_cmp++;
        if (read_addr_row !== 24'h000006) begin
            n_err++;
            $display("FAIL good_row row=%h expected 000006", read_addr_row);
        end
        bad_bytes = 0;
        for (int i = 0; i < 8192; i++) begin
            if (ram[15'h2000 + i] !== pat(i)) bad_bytes++;
        end
        n_cmp++;
        if (bad_bytes != 0 || ram_writes - w0 != 8192) begin
            n_err++;
            $display("FAIL good_ram bad_bytes=%0d writes=%0d expected 0 and 8192", bad_bytes, ram_writes - w0);
        end
        @(negedge clk);
        n_cmp++;
        if (end_read !== 1'b0 || read_status !== 2'd1) begin
            n_err++;
            $display("FAIL good_pulse end=%b status=%0d expected end=0 status=1", end_read, read_status);
        end
    endtask

    task automatic test_info_skip();
        bit ok;
        write_addr_row = 24'h001000;
        set_row(24'h00007E);
        pulse_read();
        run_page(4, 8'hFF, 2'd1, ok);
        wait_end(ok);
        n_cmp++;
        if (!ok || read_status !== 2'd1 || read_addr_row !== 24'h00007F) begin
            n_err++;
            $display("FAIL info_first end=%b status=%0d row=%h expected 1 1 00007F", ok, read_status, read_addr_row);
        end
        pulse_read();
        run_page(4, 8'hFF, 2'd1, ok);
        n_cmp++;
        if (!ok || last_req_row !== 24'h000080) begin
            n_err++;
            $display("FAIL info_jump seen=%b req_row=%h expected 1 000080", ok, last_req_row);
        end
        wait_end(ok);
        n_cmp++;
        if (!ok || read_status !== 2'd1 || read_addr_row !== 24'h000081 || info_reqs !== 0) begin
            n_err++;
            $display("FAIL info_second end=%b status=%0d row=%h info_reqs=%0d expected 1 1 000081 0",
                     ok, read_status, read_addr_row, info_reqs);
        end
    endtask

    task automatic test_bad_block();
        bit ok;
        bit ok2;
        write_addr_row = 24'h001000;
        set_row(24'h000180);
        pulse_read();
        run_page(4, 8'h00, 2'd1, ok);
        run_page(4, 8'hFF, 2'd1, ok2);
        n_cmp++;
        if (!ok || !ok2 || last_req_row !== 24'h000200) begin
            n_err++;
            $display("FAIL bad_skip seen=%b%b req_row=%h expected 11 000200", ok, ok2, last_req_row);
        end
        wait_end(ok);
        n_cmp++;
        if (!ok || read_status !== 2'd1 || read_addr_row !== 24'h000201) begin
            n_err++;
            $display("FAIL bad_status end=%b status=%0d row=%h expected 1 1 000201", ok, read_status, read_addr_row);
        end
    endtask

    task automatic test_retry_fail();
        bit ok;
        bit all_ok;
        int r0;
        write_addr_row = 24'h001000;
        set_row(24'h000020);
        r0 = rises;
        all_ok = 1'b1;
        pulse_read();
        for (int k = 0; k < 3; k++) begin
            run_page(4, 8'hFF, 2'd2, ok);
            all_ok = all_ok & ok;
        end
        wait_end(ok);
        n_cmp++;
        if (!all_ok || rises - r0 != 3) begin
            n_err++;
            $display("FAIL retry_count seen=%b requests=%0d expected 1 3", all_ok, rises - r0);
        end
        n_cmp++;
        if (!ok || read_status !== 2'd3 || read_addr_row !== 24'h000021) begin
            n_err++;
            $display("FAIL retry_status end=%b status=%0d row=%h expected 1 3 000021", ok, read_status, read_addr_row);
        end
    endtask

    task automatic test_empty();
        int r0;
        write_addr_row = 24'h000040;
        set_row(24'h000040);
        r0 = rises;
        pulse_read();
        @(negedge clk);
        n_cmp++;
        if (end_read !== 1'b1 || read_status !== 2'd2) begin
            n_err++;
            $display("FAIL empty_end end=%b status=%0d expected 1 2", end_read, read_status);
        end
        @(negedge clk);
        n_cmp++;
        if (end_read !== 1'b0 || rises - r0 != 0 || en_read_page !== 1'b0 || read_addr_row !== 24'h000040) begin
            n_err++;
            $display("FAIL empty_after end=%b requests=%0d rp=%b row=%h expected 0 0 0 000040",
                     end_read, rises - r0, en_read_page, read_addr_row);
        end
    endtask

    task automatic test_reset_midway();
        bit ok;
        write_addr_row = 24'h001000;
        set_row(24'h000010);
        pulse_read();
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (en_read_page) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL mid_req en_read_page=0 expected 1"); end
        for (int i = 0; i <= 100; i++) begin
            read_data_valid = 1'b1;
            read_data_cnt   = 14'(i);
            read_data       = pat(i);
            if (i == 100) rst = 1'b1;
            else @(negedge clk);
        end
        #1;
        n_cmp++;
        if (en_read_page !== 1'b0 || end_read !== 1'b0 || read_status !== 2'd0 || read_addr_row !== 24'd0 ||
            read_en_ram !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset rp=%b end=%b st=%0d row=%h ram=%b expected all 0",
                     en_read_page, end_read, read_status, read_addr_row, read_en_ram);
        end
        @(negedge clk);
        rst             = 1'b0;
        read_data_valid = 1'b0;
        read_data_cnt   = 14'd0;
        write_addr_row  = 24'h000005;
        pulse_read();
        run_page(4, 8'hFF, 2'd1, ok);
        wait_end(ok);
        n_cmp++;
        if (!ok || read_status !== 2'd1 || read_addr_row !== 24'h000001) begin
            n_err++;
            $display("FAIL mid_restart end=%b status=%0d row=%h expected 1 1 000001", ok, read_status, read_addr_row);
        end
    endtask

    initial begin
        rst               = 1'b1;
        en_read           = 1'b0;
        end_read_page     = 1'b0;
        read_success      = 2'd0;
        read_data_valid   = 1'b0;
        read_data_cnt     = 14'd0;
        read_data         = 8'd0;
        write_addr_row    = 24'h001000;
        init_addr_row     = 24'd0;
        en_init_read_addr = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_good_page();
        test_info_skip();
        test_bad_block();
        test_retry_fail();
        test_empty();
        test_reset_midway();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
